// File: rtl/instr_encoder_loader_pkg.sv
// Shared encoding constants and the loader FSM states.
// encode_uop turns one decoded micro-op into a MIPS R- or I-type word.
package instr_encoder_loader_pkg;

    localparam logic [3:0] ALUOP_ADD  = 4'd0;
    localparam logic [3:0] ALUOP_ADDU = 4'd1;
    localparam logic [3:0] ALUOP_SUB  = 4'd2;
    localparam logic [3:0] ALUOP_SUBU = 4'd3;
    localparam logic [3:0] ALUOP_AND  = 4'd4;
    localparam logic [3:0] ALUOP_OR   = 4'd5;
    localparam logic [3:0] ALUOP_XOR  = 4'd6;
    localparam logic [3:0] ALUOP_SLL  = 4'd7;
    localparam logic [3:0] ALUOP_SRL  = 4'd8;
    localparam logic [3:0] ALUOP_SRA  = 4'd9;
    localparam logic [3:0] ALUOP_NOP  = 4'hF;

    localparam logic [5:0] OPCODE_RTYPE = 6'h00;
    localparam logic [5:0] OPCODE_ADDI  = 6'h08;
    localparam logic [5:0] OPCODE_ADDIU = 6'h09;
    localparam logic [5:0] OPCODE_ANDI  = 6'h0C;
    localparam logic [5:0] OPCODE_ORI   = 6'h0D;
    localparam logic [5:0] OPCODE_XORI  = 6'h0E;

    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_SRA  = 6'h03;
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_XOR  = 6'h26;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } enc_state_e;

    typedef struct packed {
        logic        legal;
        logic [31:0] word;
    } enc_result_t;

    function automatic enc_result_t encode_uop(
        input logic [3:0]  aluop,
        input logic        is_imm,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  shamt,
        input logic [15:0] imm
    );
        enc_result_t res;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic        is_shift;
        res      = '0;
        opcode   = OPCODE_RTYPE;
        funct    = FUNCT_ADD;
        is_shift = 1'b0;
        res.legal = 1'b1;
        if (is_imm) begin
            case (aluop)
                ALUOP_ADD:  opcode = OPCODE_ADDI;
                ALUOP_ADDU: opcode = OPCODE_ADDIU;
                ALUOP_AND:  opcode = OPCODE_ANDI;
                ALUOP_OR:   opcode = OPCODE_ORI;
                ALUOP_XOR:  opcode = OPCODE_XORI;
                default:    res.legal = 1'b0;
            endcase
            res.word = {opcode, rs, rt, imm};
        end else begin
            case (aluop)
                ALUOP_ADD:  funct = FUNCT_ADD;
                ALUOP_ADDU: funct = FUNCT_ADDU;
                ALUOP_SUB:  funct = FUNCT_SUB;
                ALUOP_SUBU: funct = FUNCT_SUBU;
                ALUOP_AND:  funct = FUNCT_AND;
                ALUOP_OR:   funct = FUNCT_OR;
                ALUOP_XOR:  funct = FUNCT_XOR;
                ALUOP_SLL:  begin funct = FUNCT_SLL; is_shift = 1'b1; end
                ALUOP_SRL:  begin funct = FUNCT_SRL; is_shift = 1'b1; end
                ALUOP_SRA:  begin funct = FUNCT_SRA; is_shift = 1'b1; end
                default:    res.legal = 1'b0;
            endcase
            // Shifts take their operand from rt, so rs is zeroed; non-shifts never carry a shamt.
            res.word = {OPCODE_RTYPE, (is_shift ? 5'd0 : rs), rt, rd,
                        (is_shift ? shamt : 5'd0), funct};
        end
        return res;
    endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Micro-op stream, instruction-memory write port and status of the encoder/loader.
interface instr_encoder_loader_if;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [3:0]  in_aluop;
    logic        in_is_imm;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [4:0]  in_shamt;
    logic [15:0] in_imm;
    logic        imem_stall;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        err_pulse;
    logic [7:0]  err_count;
    logic        done;

    modport master (
        output start, in_valid, in_last, in_aluop, in_is_imm, in_rs, in_rt, in_rd,
               in_shamt, in_imm, imem_stall,
        input  in_ready, imem_we, imem_addr, imem_wdata, err_pulse, err_count, done
    );

    modport slave (
        input  start, in_valid, in_last, in_aluop, in_is_imm, in_rs, in_rt, in_rd,
               in_shamt, in_imm, imem_stall,
        output in_ready, imem_we, imem_addr, imem_wdata, err_pulse, err_count, done
    );
endinterface

// File: rtl/instr_encoder_loader_sync_fifo.sv
// Synchronous FIFO, power-of-two depth, synchronous active-low reset.
// Push when full and pop when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             Reset_L,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];

    always_ff @(posedge CLK) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes decoded micro-ops into MIPS words, buffers them and writes them
// sequentially into instruction memory starting at BASE_ADDR.
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_LOAD  | accepting micro-ops, draining FIFO to memory
// ST_DRAIN | last micro-op accepted, flushing remaining words
// ST_DONE  | one-cycle done pulse, back to idle
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic                  CLK,
    input  logic                  Reset_L,
    instr_encoder_loader_if.slave bus
);
    enc_state_e  r_state;
    enc_state_e  w_next_state;
    logic [31:0] r_addr;
    logic [7:0]  r_err_count;
    logic        r_err_pulse;
    logic        w_full;
    logic        w_empty;
    logic [31:0] w_head;
    logic        w_in_ready;
    logic        w_drain_en;
    logic        w_done;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;
    enc_result_t w_enc;

    always_comb begin
        w_enc = encode_uop(bus.in_aluop, bus.in_is_imm, bus.in_rs, bus.in_rt,
                           bus.in_rd, bus.in_shamt, bus.in_imm);
    end

    assign w_accept = bus.in_valid && w_in_ready;
    assign w_push   = w_accept && w_enc.legal;
    assign w_pop    = w_drain_en && !w_empty && !bus.imem_stall;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .Reset_L (Reset_L),
        .i_push  (w_push),
        .i_data  (w_enc.word),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge CLK) begin
        if (!Reset_L) r_state <= ST_IDLE;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (bus.start) w_next_state = ST_LOAD;
            ST_LOAD:  if (w_accept && bus.in_last) w_next_state = ST_DRAIN;
            ST_DRAIN: if (w_empty) w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready = 1'b0;
        w_drain_en = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            ST_LOAD:  begin w_in_ready = !w_full; w_drain_en = 1'b1; end
            ST_DRAIN: w_drain_en = 1'b1;
            ST_DONE:  w_done = 1'b1;
            default:  ;
        endcase
    end

    // Address and error bookkeeping; start re-arms both for a fresh session.
    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            r_addr      <= BASE_ADDR;
            r_err_count <= '0;
            r_err_pulse <= 1'b0;
        end else begin
            r_err_pulse <= w_accept && !w_enc.legal;
            if (r_state == ST_IDLE && bus.start) begin
                r_addr      <= BASE_ADDR;
                r_err_count <= '0;
            end else begin
                if (w_pop) r_addr <= r_addr + 32'd4;
                if (w_accept && !w_enc.legal && r_err_count != 8'hFF)
                    r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.imem_we    = w_pop;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = w_pop ? w_head : 32'h0;
    assign bus.err_pulse  = r_err_pulse;
    assign bus.err_count  = r_err_count;
    assign bus.done       = w_done;
endmodule
